// File: rtl/jk_register_bank_pkg.sv
// Shared definitions for the JK register bank: mode encodings and the JK
// characteristic equation used by every storage cell.
package jk_register_bank_pkg;

  localparam logic [1:0] MODE_JK    = 2'd0;
  localparam logic [1:0] MODE_T     = 2'd1;
  localparam logic [1:0] MODE_D     = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  // JK characteristic equation: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_register_bank_cell.sv
// Single JK storage bit with synchronous reset, set and clock enable.
// Priority is reset, then set, then enable; it also exposes the value it
// will take on the next edge so the bank can detect changes.
module jk_cell
  import jk_register_bank_pkg::*;
(
  input  logic i_clk,
  input  logic i_r,
  input  logic i_s,
  input  logic i_ce,
  input  logic i_j,
  input  logic i_k,
  input  logic i_init,
  input  logic i_set,
  output logic o_q,
  output logic o_q_next
);

  logic r_q;

  assign o_q = r_q;

  // Next-state selection in priority order: reset, set, enable, hold.
  always_comb begin
    o_q_next = r_q;
    if (i_r) begin
      o_q_next = i_init;
    end else if (i_s) begin
      o_q_next = i_set;
    end else if (i_ce) begin
      o_q_next = jk_next(r_q, i_j, i_k);
    end
  end

  // State register; reset and set are folded into the next-state logic.
  always_ff @(posedge i_clk) begin
    r_q <= o_q_next;
  end

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK cells with run-time mode select: per-bit JK, T or D,
// or the whole bank as an up/down counter built from the same JK cells.
// Tc is a combinational terminal-count flag for cascading; Changed reports
// whether the previous edge altered Qout (reset edges never count).
module jk_register_bank
  import jk_register_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             S,
  input  logic             CE,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             Dir,
  output logic [WIDTH-1:0] Qout,
  output logic             Tc,
  output logic             Changed
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_carry;
  logic             r_changed;

  assign Qout    = w_q;
  assign Changed = r_changed;

  // Count-enable chain: bit i toggles when every lower bit is 1 (up) or 0
  // (down); bit 0 always toggles. Each term is a flat reduction so the
  // chain has no combinational self-dependency.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign w_carry[gi] = 1'b1;
      end else begin : g_upper
        assign w_carry[gi] = Dir ? ~(|w_q[gi-1:0]) : (&w_q[gi-1:0]);
      end

      jk_cell u_cell (
        .i_clk    (Clk),
        .i_r      (R),
        .i_s      (S),
        .i_ce     (CE),
        .i_j      (w_j[gi]),
        .i_k      (w_k[gi]),
        .i_init   (INIT[gi]),
        .i_set    (SET_VALUE[gi]),
        .o_q      (w_q[gi]),
        .o_q_next (w_q_next[gi])
      );
    end
  endgenerate

  // Mode decode: map the external J/K (or the count chain) onto cell J/K.
  always_comb begin
    w_j = J;
    w_k = K;
    case (Mode)
      MODE_JK: begin
        w_j = J;
        w_k = K;
      end
      MODE_T: begin
        w_j = J;
        w_k = J;
      end
      MODE_D: begin
        w_j = J;
        w_k = ~J;
      end
      default: begin
        w_j = w_carry;
        w_k = w_carry;
      end
    endcase
  end

  // Terminal count: all-ones going up or all-zeros going down, COUNT mode only.
  assign Tc = (Mode == MODE_COUNT) &&
              (Dir ? (w_q == {WIDTH{1'b0}}) : (w_q == {WIDTH{1'b1}}));

  // Change flag: compare the value being loaded with the current one.
  always_ff @(posedge Clk) begin
    if (R) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= (w_q_next != w_q);
    end
  end

endmodule

// File: tb/tb_jk_register_bank.sv
// Randomised and directed bench for jk_register_bank with a queue-based
// scoreboard and a behavioural reference model.
module tb_jk_register_bank;

  localparam int         W     = 8;
  localparam logic [7:0] INITV = 8'h00;
  localparam logic [7:0] SETV  = 8'hFF;

  logic         Clk = 1'b0;
  logic         R, S, CE, Dir;
  logic [1:0]   Mode;
  logic [W-1:0] J, K;
  logic [W-1:0] Qout;
  logic         Tc, Changed;

  jk_register_bank #(.WIDTH(W), .INIT(INITV), .SET_VALUE(SETV)) dut (
    .Clk(Clk), .R(R), .S(S), .CE(CE), .Mode(Mode), .J(J), .K(K),
    .Dir(Dir), .Qout(Qout), .Tc(Tc), .Changed(Changed)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         chg;
    logic         tc;
    logic [15:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_q;
  logic         m_chg;
  int           step_id = 0;

  // Reference: what the bank should hold after one edge with these inputs.
  function automatic logic [W-1:0] model_next(
    input logic [W-1:0] q, input logic r, input logic s, input logic ce,
    input logic [1:0] md, input logic [W-1:0] j, input logic [W-1:0] k,
    input logic d);
    logic [W-1:0] n;
    if (r)       n = INITV;
    else if (s)  n = SETV;
    else if (!ce) n = q;
    else begin
      case (md)
        2'd0:    n = (j & ~q) | (~k & q);
        2'd1:    n = q ^ j;
        2'd2:    n = j;
        default: n = d ? q - 8'd1 : q + 8'd1;
      endcase
    end
    return n;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] q, input logic [1:0] md,
                                    input logic d);
    return (md == 2'd3) && (d ? (q == 8'h00) : (q == 8'hFF));
  endfunction

  // Apply one cycle of inputs; queue what the DUT must show during this
  // cycle, then advance the model across the coming edge.
  task automatic step(input logic r, input logic s, input logic ce,
                      input logic [1:0] md, input logic [W-1:0] j,
                      input logic [W-1:0] k, input logic d);
    exp_t e;
    logic [W-1:0] n;
    R = r; S = s; CE = ce; Mode = md; J = j; K = k; Dir = d;
    e.q   = m_q;
    e.chg = m_chg;
    e.tc  = model_tc(m_q, md, d);
    e.id  = step_id[15:0];
    exp_q.push_back(e);
    step_id++;
    n     = model_next(m_q, r, s, ce, md, j, k, d);
    m_chg = r ? 1'b0 : (n != m_q);
    m_q   = n;
    @(posedge Clk);
    #1;
  endtask

  // Monitor: the DUT presents a state every cycle; check it mid-cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (Qout !== e.q) begin
        errors++;
        $display("FAIL qout step %0d: got %h expected %h", e.id, Qout, e.q);
      end
      checks++;
      if (Changed !== e.chg) begin
        errors++;
        $display("FAIL changed step %0d: got %b expected %b", e.id, Changed, e.chg);
      end
      checks++;
      if (Tc !== e.tc) begin
        errors++;
        $display("FAIL tc step %0d: got %b expected %b", e.id, Tc, e.tc);
      end
    end
  end

  initial begin
    int budget;
    R = 1'b1; S = 1'b0; CE = 1'b0; Mode = 2'd0; J = '0; K = '0; Dir = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    m_q = INITV;
    m_chg = 1'b0;

    // Enable low: nothing moves whatever J/K/Mode are.
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));

    // JK mode from 0F with J=F0, K=3C.
    step(0, 0, 1, 2'd2, 8'h0F, 8'h00, 0);
    step(0, 0, 1, 2'd0, 8'hF0, 8'h3C, 0);
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);

    // Count up through wrap, then down through zero.
    step(0, 0, 1, 2'd2, 8'hFD, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'd3, 8'h00, 8'h00, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 2'd3, 8'h00, 8'h00, 1);
    step(0, 0, 0, 2'd3, 8'h00, 8'h00, 1);

    // Reset beats set, set beats enable.
    step(1, 1, 1, 2'd3, 8'h00, 8'h00, 0);
    step(0, 1, 1, 2'd3, 8'h00, 8'h00, 0);
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);

    // D mode with an enable gap.
    step(0, 0, 1, 2'd2, 8'hA5, 8'h00, 0);
    step(0, 0, 0, 2'd2, 8'h5A, 8'h00, 0);
    step(0, 0, 1, 2'd2, 8'h5A, 8'h00, 0);
    step(0, 0, 0, 2'd2, 8'h00, 8'h00, 0);

    // T mode twice with all ones returns to start.
    step(0, 0, 1, 2'd1, 8'hFF, 8'h00, 0);
    step(0, 0, 1, 2'd1, 8'hFF, 8'h00, 0);
    step(0, 0, 0, 2'd1, 8'h00, 8'h00, 0);

    // Frozen counter at each terminal value while Dir flips.
    step(0, 1, 0, 2'd3, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'd3, 8'h00, 8'h00, 1'(i));
    step(1, 0, 0, 2'd3, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'd3, 8'h00, 8'h00, 1'(i));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), 1'($urandom));
    end
    step(0, 0, 0, 2'd3, 8'h00, 8'h00, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge Clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
